// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises a 2-bit command plus payload per SS_n frame and
// strobes it to the RAM; read-data commands wait (bounded) for tx_valid and shift the response out on MISO.
module spi_slave_param #(
  parameter int PAYLOAD_W  = 8,
  parameter int TX_W       = 8,
  parameter int TX_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [TX_W-1:0]      tx_data,
  input  logic                 tx_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int N  = PAYLOAD_W + 2;
  localparam int BW = $clog2(N + 1);
  localparam int WW = $clog2(TX_TIMEOUT + 1);
  localparam int TW = $clog2(TX_W + 1);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   bitcnt;
  logic [WW-1:0]   waitcnt;
  logic [TW-1:0]   txcnt;
  logic [N-2:0]    shift;
  logic [TX_W-1:0] txreg;
  logic            last_bit, is_rd, timeout, tx_last;

  // last_bit: the current edge samples frame bit N; the command sits in the two oldest shifted bits
  assign last_bit = (bitcnt == BW'(N - 1));
  assign is_rd    = shift[N-2] & shift[N-3];
  assign timeout  = (waitcnt == WW'(TX_TIMEOUT));
  assign tx_last  = (txcnt == TW'(TX_W));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SS_n) state_nxt = RECV;
      RECV: begin
        if (SS_n)          state_nxt = IDLE;
        else if (last_bit) state_nxt = is_rd ? WAIT_TX : DONE;
      end
      // SS_n release has priority over tx_valid and the timeout
      WAIT_TX: begin
        if (SS_n)          state_nxt = IDLE;
        else if (tx_valid) state_nxt = SEND;
        else if (timeout)  state_nxt = DONE;
      end
      SEND: begin
        if (SS_n)          state_nxt = IDLE;
        else if (tx_last)  state_nxt = DONE;
      end
      DONE:    if (SS_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      waitcnt   <= '0;
      txcnt     <= '0;
      shift     <= '0;
      txreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
      case (state)
        IDLE: begin
          if (!SS_n) begin
            shift  <= {{(N-2){1'b0}}, MOSI};
            bitcnt <= BW'(1);
          end
        end
        RECV: begin
          if (SS_n) begin
            frame_err <= 1'b1;
          end else begin
            shift  <= {shift[N-3:0], MOSI};
            bitcnt <= bitcnt + 1'b1;
            if (last_bit) begin
              rx_data  <= {shift, MOSI};
              rx_valid <= 1'b1;
              waitcnt  <= '0;
            end
          end
        end
        WAIT_TX: begin
          if (!SS_n) begin
            if (tx_valid) begin
              txreg <= tx_data << 1;
              MISO  <= tx_data[TX_W-1];
              txcnt <= TW'(1);
            end else if (timeout) begin
              frame_err <= 1'b1;
            end else begin
              waitcnt <= waitcnt + 1'b1;
            end
          end
        end
        // txreg is pre-shifted so its MSB is always the next bit to drive
        SEND: begin
          if (!SS_n && !tx_last) begin
            MISO  <= txreg[TX_W-1];
            txreg <= txreg << 1;
            txcnt <= txcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: default instance plus a PAYLOAD_W=14/TX_W=16 instance.
module tb_spi_slave_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        ss_a = 1'b1, mosi_a = 1'b0, miso_a, rxv_a, ferr_a, busy_a, txv_a = 1'b0;
  logic [9:0]  rxd_a;
  logic [7:0]  txd_a = '0;
  logic        ss_b = 1'b1, mosi_b = 1'b0, miso_b, rxv_b, ferr_b, busy_b, txv_b = 1'b0;
  logic [15:0] rxd_b;
  logic [15:0] txd_b = '0;

  spi_slave_param dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a),
    .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(txd_a), .tx_valid(txv_a),
    .frame_err(ferr_a), .busy(busy_a)
  );

  spi_slave_param #(.PAYLOAD_W(14), .TX_W(16), .TX_TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b),
    .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(txd_b), .tx_valid(txv_b),
    .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {int k; logic [31:0] v;} rx_e_t;
  typedef struct {int k; logic [31:0] w; int n;} tx_e_t;
  rx_e_t rxq[$];
  tx_e_t txq[$];

  int total = 0;
  int bad = 0;
  int err_exp[2] = '{0, 0};
  int mcnt[2] = '{-1, -1};
  int mexpn[2] = '{0, 0};
  logic [31:0] mword[2];
  logic [31:0] mexpw[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: pops expected rx words / error pulses / MISO words as the DUT presents them
  task automatic mon(input int k, input logic rxv, input logic [31:0] rxd, input logic ferr,
                     input logic miso, input logic txv, input int txw);
    rx_e_t r;
    tx_e_t t;
    if (rxv) begin
      if (rxq.size() > 0 && rxq[0].k == k) begin
        r = rxq.pop_front();
        chk($sformatf("rx_data%0d", k), rxd, r.v);
      end else flag($sformatf("rx_valid_unexpected%0d", k));
    end
    if (ferr) begin
      if (rxv) flag($sformatf("rx_err_overlap%0d", k));
      if (err_exp[k] > 0) begin
        err_exp[k]--;
        chk($sformatf("frame_err%0d", k), 32'(ferr), 32'd1);
      end else flag($sformatf("frame_err_unexpected%0d", k));
    end
    if (mcnt[k] >= 0) begin
      mword[k] = {mword[k][30:0], miso};
      mcnt[k]++;
      if (mcnt[k] == mexpn[k]) begin
        chk($sformatf("miso_word%0d", k), mword[k], mexpw[k] >> (txw - mexpn[k]));
        mcnt[k] = -1;
      end
    end else begin
      chk($sformatf("miso_idle%0d", k), 32'(miso), 32'd0);
      if (txv && txq.size() > 0 && txq[0].k == k) begin
        t = txq.pop_front();
        mcnt[k] = 0;
        mword[k] = '0;
        mexpn[k] = t.n;
        mexpw[k] = t.w;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt[0] = -1;
      mcnt[1] = -1;
    end else begin
      mon(0, rxv_a, 32'(rxd_a), ferr_a, miso_a, txv_a, 8);
      mon(1, rxv_b, 32'(rxd_b), ferr_b, miso_b, txv_b, 16);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int k, input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      if (k == 0) begin ss_a = 1'b0; mosi_a = bits[i]; end
      else        begin ss_b = 1'b0; mosi_b = bits[i]; end
      cyc(1);
    end
  endtask

  task automatic release_ss(input int k);
    if (k == 0) ss_a = 1'b1; else ss_b = 1'b1;
    cyc(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_miso", 32'(miso_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_rxv", 32'(rxv_a), 0);
    chk("rst_ferr", 32'(ferr_a), 0);
    chk("rst_rxd", 32'(rxd_a), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // 1: write frame
    rxq.push_back('{0, 32'h0A5});
    frame(0, 10, 32'b0010100101);
    cyc(2);
    chk("busy_done", 32'(busy_a), 1);
    release_ss(0);
    chk("busy_idle", 32'(busy_a), 0);

    // 2: read-data frame with response C3, frame starts right after IDLE
    rxq.push_back('{0, 32'h300});
    frame(0, 10, 32'h300);
    cyc(2);
    txd_a = 8'hC3; txv_a = 1'b1;
    txq.push_back('{0, 32'hC3, 8});
    cyc(1);
    txv_a = 1'b0;
    cyc(10);
    release_ss(0);

    // 3: abort after 5 bits
    err_exp[0]++;
    frame(0, 5, 32'b11010);
    release_ss(0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_rxd_hold", 32'(rxd_a), 32'h300);
    cyc(2);

    // 4: response timeout, late tx_valid ignored
    rxq.push_back('{0, 32'h3F0});
    frame(0, 10, 32'h3F0);
    err_exp[0]++;
    cyc(15);
    chk("timeout_early", 32'(ferr_a), 0);
    cyc(1);
    chk("timeout_edge", 32'(ferr_a), 1);
    txd_a = 8'hFF; txv_a = 1'b1;
    cyc(2);
    txv_a = 1'b0;
    chk("timeout_busy", 32'(busy_a), 1);
    cyc(3);
    release_ss(0);

    // 5: async reset during SEND after 3 bits of B4 (third bit is 1)
    rxq.push_back('{0, 32'h3AA});
    frame(0, 10, 32'h3AA);
    txd_a = 8'hB4; txv_a = 1'b1;
    txq.push_back('{0, 32'hB4, 3});
    @(posedge clk); #1;
    txv_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #6;
    rst_n = 1'b0;
    #1;
    chk("arst_miso", 32'(miso_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_rxv", 32'(rxv_a), 0);
    ss_a = 1'b1;
    #1;
    rst_n = 1'b1;
    cyc(1);
    rxq.push_back('{0, 32'h1C3});
    frame(0, 10, 32'h1C3);
    release_ss(0);

    // 6: wide instance, 16-bit frame and response
    rxq.push_back('{1, 32'hDABC});
    frame(1, 16, 32'hDABC);
    cyc(2);
    txd_b = 16'hA55A; txv_b = 1'b1;
    txq.push_back('{1, 32'hA55A, 16});
    cyc(1);
    txv_b = 1'b0;
    cyc(20);
    release_ss(1);
    cyc(3);

    chk("rxq_drained", 32'(rxq.size()), 0);
    chk("txq_drained", 32'(txq.size()), 0);
    chk("err_drained_a", 32'(err_exp[0]), 0);
    chk("err_drained_b", 32'(err_exp[1]), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end for the RAM subsystem.
- Deserialises one command-plus-payload frame per SS_n assertion and presents it to the RAM as a parallel word with a one-cycle rx_valid strobe.
- For read-data commands, waits for the RAM response and serialises it out on MISO.
- Compared with the fixed 10-bit slave, this block adds:
  - configurable payload and response widths;
  - a bounded response wait with timeout;
  - frame-error reporting;
  - a busy indication.

Parameters:
- PAYLOAD_W, 8, number of address/data bits following the 2-bit command field.
- TX_W, 8, width of the RAM read response shifted out on MISO.
- TX_TIMEOUT, 15, maximum wait cycles for tx_valid after a read-data frame (must be at least 1).

Ports:
- clk  input  1  system clock; SS_n, MOSI and tx_valid are sampled on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  PAYLOAD_W+2  received frame; bits [PAYLOAD_W+1:PAYLOAD_W] are the command.
- rx_valid  output  1  one-cycle strobe, rx_data valid.
- tx_data  input  TX_W  read data from RAM.
- tx_valid  input  1  tx_data valid; sampled only in WAIT_TX.
- frame_err  output  1  one-cycle pulse on aborted frame or response timeout.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Definition: N = PAYLOAD_W+2. All state updates occur on the rising edge of clk.
- Reset (async, rst_n=0): state=IDLE; MISO, rx_valid, frame_err and busy are 0; rx_data=0; bit counter, wait counter and shift registers are cleared. Reset mid-frame discards the frame with no strobes.
- Command encoding: 00 write address, 01 write data, 10 read address, 11 read data. Only 11 produces a MISO response; the others only strobe rx_valid.
- IDLE:
  - SS_n=0 at an edge samples MOSI as frame bit 1, sets bitcnt=1 and moves to RECV.
  - SS_n=1 stays in IDLE.
- RECV:
  - Each edge with SS_n=0 shifts MOSI into the shift register LSB and increments bitcnt.
  - At the edge that samples bit N: rx_data <= {shift[N-2:0], MOSI} and rx_valid <= 1 for exactly one cycle.
  - Next state from that edge: WAIT_TX if the command is 11, otherwise DONE.
  - SS_n=1 with bitcnt<N: go to IDLE, pulse frame_err for one cycle, leave rx_data unchanged, no rx_valid.
- WAIT_TX:
  - waitcnt starts at 0 on entry and increments each edge with tx_valid=0.
  - tx_valid=1: capture tx_data into txreg, MISO <= tx_data[TX_W-1], txcnt=1, go to SEND.
  - waitcnt==TX_TIMEOUT and tx_valid=0: pulse frame_err, go to DONE. MISO stays 0.
- SEND:
  - Each edge drives MISO <= txreg[TX_W-1-txcnt] and increments txcnt.
  - After bit 0 has been driven for one cycle, MISO returns to 0 and state goes to DONE.
  - Total: TX_W consecutive MISO bits, one per cycle.
- DONE: MOSI is ignored; stay until SS_n=1, then go to IDLE.
- SS_n=1 in WAIT_TX, SEND or DONE: go to IDLE next edge, MISO <= 0, no frame_err (master-terminated read is legal).
- Priority: SS_n=1 beats tx_valid and timeout on the same edge.
- MISO is 0 in every state except SEND.
- rx_valid and frame_err are never high in the same cycle.
- A new frame may begin on the edge immediately after IDLE is entered.

Test Plan:
1. Write frame, PAYLOAD_W=8: SS_n low, MOSI bits 0,0,1,0,1,0,0,1,0,1 -> rx_data=10'h0A5 and rx_valid high for one cycle after the 10th edge; MISO stays 0; busy stays high until SS_n high.
2. Read-data frame 11_00000000, tx_valid asserted 3 cycles later with tx_data=8'hC3 -> MISO shows 1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0; frame_err stays 0.
3. Abort: SS_n deasserted after 5 bits -> frame_err pulses once, no rx_valid, rx_data holds its previous value, busy=0 the next cycle.
4. Timeout: read-data frame with tx_valid held 0 -> frame_err pulses on the 16th edge in WAIT_TX (TX_TIMEOUT=15), MISO stays 0, and a later tx_valid is ignored until the next frame.
5. Reset: rst_n pulsed low during SEND after 3 bits -> MISO, busy and rx_valid are 0 immediately (asynchronously); a following write frame is received correctly.
6. Parameters PAYLOAD_W=14, TX_W=16: read-data frame 11 + 14'h1ABC -> rx_data=16'hDABC, and a 16-bit response 16'hA55A is shifted out MSB first.
